// File: rtl/bcd_timer_pkg.sv
// Shared types and constants for the BCD countdown/stopwatch controller.
// Holds the FSM encoding, BCD limit, count-direction constants and a digit check.
package bcd_timer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  localparam logic MODE_DOWN = 1'b0;
  localparam logic MODE_UP   = 1'b1;

  function automatic logic is_bcd(input logic [3:0] d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_pair_counter.sv
// Two-digit BCD up/down counter with load, clear and saturating ends.
// Ports: clk, clr (async active-low), en, load, clear, up, d_u/d_t in; q_u/q_t, term out.
module bcd_pair_counter
  import bcd_timer_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       en,
  input  logic       load,
  input  logic       clear,
  input  logic       up,
  input  logic [3:0] d_u,
  input  logic [3:0] d_t,
  output logic [3:0] q_u,
  output logic [3:0] q_t,
  output logic       term
);

  logic [3:0] nx_u;
  logic [3:0] nx_t;

  // Next value one count away; the ends saturate so Q stays BCD.
  always_comb begin
    nx_u = q_u;
    nx_t = q_t;
    if (up) begin
      if (q_u == BCD_MAX) begin
        if (q_t != BCD_MAX) begin
          nx_u = BCD_MIN;
          nx_t = q_t + 4'd1;
        end
      end else begin
        nx_u = q_u + 4'd1;
      end
    end else begin
      if (q_u == BCD_MIN) begin
        if (q_t != BCD_MIN) begin
          nx_u = BCD_MAX;
          nx_t = q_t - 4'd1;
        end
      end else begin
        nx_u = q_u - 4'd1;
      end
    end
  end

  // Terminal flag describes the value a count would produce.
  always_comb begin
    if (up)
      term = (nx_t == BCD_MAX) && (nx_u == BCD_MAX);
    else
      term = (nx_t == BCD_MIN) && (nx_u == BCD_MIN);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      q_u <= '0;
      q_t <= '0;
    end else if (clear) begin
      q_u <= '0;
      q_t <= '0;
    end else if (load) begin
      q_u <= d_u;
      q_t <= d_t;
    end else if (en) begin
      q_u <= nx_u;
      q_t <= nx_t;
    end
  end

endmodule

// File: rtl/bcd_timer_ctrl.sv
// Countdown timer / saturating stopwatch sequencer for a 2-digit BCD counter.
// Ports: CLK, CLR, SET_U/SET_T, MODE, START, STOP in; Q_U/Q_T, RUN, DONE, ALARM, ERR out.
module bcd_timer_ctrl
  import bcd_timer_pkg::*;
#(
  parameter int TICK_DIV    = 100000000,
  parameter int DIV_W       = 27,
  parameter int ALARM_TICKS = 5
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic [3:0] SET_U,
  input  logic [3:0] SET_T,
  input  logic       MODE,
  input  logic       START,
  input  logic       STOP,
  output logic [3:0] Q_U,
  output logic [3:0] Q_T,
  output logic       RUN,
  output logic       DONE,
  output logic       ALARM,
  output logic       ERR
);

  localparam int AW = $clog2(ALARM_TICKS + 1);
  localparam logic [DIV_W-1:0] TICK_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_TICKS - 1);

  state_t state;
  state_t state_n;

  logic [DIV_W-1:0] presc;
  logic [DIV_W-1:0] presc_n;
  logic [AW-1:0]    acnt;
  logic [AW-1:0]    acnt_n;
  logic             mode;
  logic             mode_n;
  logic             alarm_n;
  logic             err_n;

  logic cnt_en;
  logic cnt_load;
  logic cnt_clear;
  logic term;
  logic tick;
  logic set_ok;
  logic set_term;

  assign tick   = (presc == TICK_LAST);
  assign set_ok = is_bcd(SET_T) && is_bcd(SET_U);

  // A preset already at the end of its count has nothing to run.
  always_comb begin
    if (MODE == MODE_UP)
      set_term = (SET_T == BCD_MAX) && (SET_U == BCD_MAX);
    else
      set_term = (SET_T == BCD_MIN) && (SET_U == BCD_MIN);
  end

  bcd_pair_counter u_cnt (
    .clk   (CLK),
    .clr   (CLR),
    .en    (cnt_en),
    .load  (cnt_load),
    .clear (cnt_clear),
    .up    (mode),
    .d_u   (SET_U),
    .d_t   (SET_T),
    .q_u   (Q_U),
    .q_t   (Q_T),
    .term  (term)
  );

  always_comb begin
    state_n   = state;
    presc_n   = presc;
    acnt_n    = acnt;
    mode_n    = mode;
    alarm_n   = ALARM;
    err_n     = 1'b0;
    cnt_en    = 1'b0;
    cnt_load  = 1'b0;
    cnt_clear = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!STOP && START) begin
          if (set_ok) begin
            cnt_load = 1'b1;
            mode_n   = MODE;
            presc_n  = '0;
            if (set_term) begin
              state_n = S_DONE;
              alarm_n = 1'b1;
              acnt_n  = '0;
            end else begin
              state_n = S_RUN;
            end
          end else begin
            err_n = 1'b1;
          end
        end
      end
      S_RUN: begin
        presc_n = tick ? '0 : presc + DIV_W'(1);
        cnt_en  = tick;
        // Terminal tick beats a same-edge STOP.
        if (tick && term) begin
          state_n = S_DONE;
          alarm_n = 1'b1;
          acnt_n  = '0;
        end else if (STOP) begin
          state_n = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (STOP) begin
          state_n   = S_IDLE;
          cnt_clear = 1'b1;
        end else if (START) begin
          state_n = S_RUN;
        end
      end
      S_DONE: begin
        presc_n = tick ? '0 : presc + DIV_W'(1);
        if (ALARM && tick) begin
          acnt_n = acnt + AW'(1);
          if (acnt == ALARM_LAST)
            alarm_n = 1'b0;
        end
        if (START || STOP) begin
          state_n   = S_IDLE;
          cnt_clear = 1'b1;
          alarm_n   = 1'b0;
          acnt_n    = '0;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state <= S_IDLE;
      presc <= '0;
      acnt  <= '0;
      mode  <= MODE_DOWN;
      ALARM <= 1'b0;
      ERR   <= 1'b0;
    end else begin
      state <= state_n;
      presc <= presc_n;
      acnt  <= acnt_n;
      mode  <= mode_n;
      ALARM <= alarm_n;
      ERR   <= err_n;
    end
  end

  assign RUN  = (state == S_RUN);
  assign DONE = (state == S_DONE);

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Directed bench for bcd_timer_ctrl with TICK_DIV=4, ALARM_TICKS=2.
// Vector table plus hand sequences for alarm width and async reset.
module tb_bcd_timer_ctrl;

  logic       CLK = 1'b0;
  logic       CLR;
  logic [3:0] SET_U;
  logic [3:0] SET_T;
  logic       MODE;
  logic       START;
  logic       STOP;
  logic [3:0] Q_U;
  logic [3:0] Q_T;
  logic       RUN;
  logic       DONE;
  logic       ALARM;
  logic       ERR;

  int checks = 0;
  int failures = 0;

  bcd_timer_ctrl #(
    .TICK_DIV    (4),
    .DIV_W       (3),
    .ALARM_TICKS (2)
  ) dut (
    .CLK   (CLK),
    .CLR   (CLR),
    .SET_U (SET_U),
    .SET_T (SET_T),
    .MODE  (MODE),
    .START (START),
    .STOP  (STOP),
    .Q_U   (Q_U),
    .Q_T   (Q_T),
    .RUN   (RUN),
    .DONE  (DONE),
    .ALARM (ALARM),
    .ERR   (ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] st;
    logic [3:0] su;
    logic       md;
    logic       sa;
    logic       sp;
    int         n;
    logic [11:0] exp;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    input logic [3:0] st, input logic [3:0] su,
    input logic md, input logic sa, input logic sp, input int n,
    input logic [3:0] qt, input logic [3:0] qu,
    input logic run, input logic done, input logic alarm, input logic err);
    vec_t v;
    v.st = st; v.su = su; v.md = md; v.sa = sa; v.sp = sp; v.n = n;
    v.exp = {qt, qu, run, done, alarm, err};
    return v;
  endfunction

  function automatic logic [11:0] outs();
    return {Q_T, Q_U, RUN, DONE, ALARM, ERR};
  endfunction

  task automatic check(input string name, input logic [11:0] got,
                       input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got Q=%h%h run=%b done=%b alarm=%b err=%b, want Q=%h%h run=%b done=%b alarm=%b err=%b",
        name, got[11:8], got[7:4], got[3], got[2], got[1], got[0],
        exp[11:8], exp[7:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Inputs held for the first edge only, then n-1 idle edges, sample at +1.
  task automatic apply(input vec_t v, input string name);
    SET_T = v.st; SET_U = v.su; MODE = v.md;
    START = v.sa; STOP = v.sp;
    @(posedge CLK); #1;
    START = 1'b0; STOP = 1'b0;
    for (int k = 1; k < v.n; k++) begin
      @(posedge CLK); #1;
    end
    check(name, outs(), v.exp);
  endtask

  initial begin
    int hi;
    int w;
    CLR = 1'b0;
    SET_U = 4'd0; SET_T = 4'd0; MODE = 1'b0;
    START = 1'b0; STOP = 1'b0;
    #3;
    check("reset", outs(), 12'h000);
    #9 CLR = 1'b1;
    @(posedge CLK); #1;

    // countdown 12
    tv.push_back(mk(1,2,0,1,0,1,  1,2,1,0,0,0));
    tv.push_back(mk(1,2,0,0,0,4,  1,1,1,0,0,0));
    tv.push_back(mk(1,2,0,0,0,4,  1,0,1,0,0,0));
    tv.push_back(mk(1,2,0,0,0,4,  0,9,1,0,0,0));
    tv.push_back(mk(1,2,0,0,0,36, 0,0,0,1,1,0));
    tv.push_back(mk(1,2,0,0,0,7,  0,0,0,1,1,0));
    tv.push_back(mk(1,2,0,0,0,1,  0,0,0,1,0,0));
    tv.push_back(mk(1,2,0,1,0,1,  0,0,0,0,0,0));
    // stopwatch 97
    tv.push_back(mk(9,7,1,1,0,1,  9,7,1,0,0,0));
    tv.push_back(mk(9,7,1,0,0,4,  9,8,1,0,0,0));
    tv.push_back(mk(9,7,1,0,0,4,  9,9,0,1,1,0));
    tv.push_back(mk(9,7,1,0,0,20, 9,9,0,1,0,0));
    tv.push_back(mk(9,7,1,1,0,1,  0,0,0,0,0,0));
    // invalid preset
    tv.push_back(mk(10,3,0,1,0,1, 0,0,0,0,0,1));
    tv.push_back(mk(10,3,0,0,0,1, 0,0,0,0,0,0));
    // preset 00 countdown, then STOP leaves DONE
    tv.push_back(mk(0,0,0,1,0,1,  0,0,0,1,1,0));
    tv.push_back(mk(0,0,0,0,1,1,  0,0,0,0,0,0));
    // STOP wins in IDLE; STOP alone is ignored
    tv.push_back(mk(0,5,0,1,1,1,  0,0,0,0,0,0));
    tv.push_back(mk(0,5,0,0,1,3,  0,0,0,0,0,0));
    // pause / resume / abort
    tv.push_back(mk(5,0,0,1,0,2,  5,0,1,0,0,0));
    tv.push_back(mk(5,0,0,0,1,1,  5,0,0,0,0,0));
    tv.push_back(mk(5,0,0,0,0,10, 5,0,0,0,0,0));
    tv.push_back(mk(5,0,0,1,0,1,  5,0,1,0,0,0));
    tv.push_back(mk(5,0,0,0,0,1,  5,0,1,0,0,0));
    tv.push_back(mk(5,0,0,0,0,1,  4,9,1,0,0,0));
    tv.push_back(mk(5,0,0,0,1,1,  4,9,0,0,0,0));
    tv.push_back(mk(5,0,0,1,1,1,  0,0,0,0,0,0));
    // terminal tick with STOP on the same edge
    tv.push_back(mk(0,1,0,1,0,4,  0,1,1,0,0,0));
    tv.push_back(mk(0,1,0,0,1,1,  0,0,0,1,1,0));
    tv.push_back(mk(0,1,0,1,0,1,  0,0,0,0,0,0));
    // preset 99 stopwatch goes straight to DONE
    tv.push_back(mk(9,9,1,1,0,1,  9,9,0,1,1,0));
    tv.push_back(mk(9,9,1,0,1,1,  0,0,0,0,0,0));
    // bad units digit
    tv.push_back(mk(3,15,1,1,0,1, 0,0,0,0,0,1));
    tv.push_back(mk(3,15,1,0,0,1, 0,0,0,0,0,0));

    for (int i = 0; i < tv.size(); i++)
      apply(tv[i], $sformatf("vec%0d", i));

    // alarm width: countdown 02, ALARM high for 2*4 cycles
    SET_T = 4'd0; SET_U = 4'd2; MODE = 1'b0; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    w = 0;
    while (!ALARM && w < 100) begin
      @(posedge CLK); #1;
      w++;
    end
    hi = 0;
    while (ALARM && hi < 100) begin
      @(posedge CLK); #1;
      hi++;
    end
    check("alarm_width", 12'(hi), 12'd8);
    check("done_hold", outs(), {4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0});
    STOP = 1'b1;
    @(posedge CLK); #1;
    STOP = 1'b0;
    check("done_abort", outs(), 12'h000);

    // asynchronous reset mid-run
    SET_T = 4'd3; SET_U = 4'd4; MODE = 1'b0; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    check("pre_reset", outs(), {4'd3, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0});
    #2 CLR = 1'b0;
    #1;
    check("async_reset", outs(), 12'h000);
    #3 CLR = 1'b1;
    repeat (12) @(posedge CLK);
    #1;
    check("post_reset_idle", outs(), 12'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_timer_ctrl.md
Name: bcd_timer_ctrl

Overview:
Controller that sequences a 2-digit BCD counter datapath as a countdown timer or a saturating stopwatch. It loads a preset, runs from a prescaled tick, and supports pause, resume and abort. At terminal count it raises DONE and a timed ALARM. It sits between board switches/buttons and the BCD display path, and replaces ad-hoc ENABLE/LOAD/UP wiring of the digit counters.

Parameters:
TICK_DIV, 100000000, CLK cycles per count tick (minimum 2)
DIV_W, 27, prescaler width; must satisfy 2^DIV_W >= TICK_DIV
ALARM_TICKS, 5, number of ticks ALARM stays high after entering DONE (minimum 1)

Ports:
CLK  in  1  system clock, rising edge
CLR  in  1  reset, asynchronous, active-low
SET_U  in  4  preset units digit (BCD)
SET_T  in  4  preset tens digit (BCD)
MODE  in  1  1 = count up (stopwatch), 0 = count down (timer); sampled only in IDLE
START  in  1  start/resume request, level sampled each edge
STOP  in  1  pause/abort request, level sampled each edge
Q_U  out  4  units digit
Q_T  out  4  tens digit
RUN  out  1  high while in RUN
DONE  out  1  high while in DONE
ALARM  out  1  alarm strobe
ERR  out  1  one-cycle pulse on rejected preset

Behaviour:
- Reset (CLR low, asynchronous): state IDLE, Q_T = Q_U = 0, prescaler = 0, alarm counter = 0, captured mode = 0, and RUN, DONE, ALARM and ERR all 0. All outputs are registered.
- States: IDLE, RUN, PAUSE, DONE. Encoding lives in the package.
- STOP has priority over START when both are high in the same cycle.
- IDLE:
  - START with SET_T <= 9 and SET_U <= 9: at that edge, load Q from SET, capture MODE, clear the prescaler.
  - Next state after a valid START is RUN. Exception: mode 0 with preset 00 goes to DONE, and mode 1 with preset 99 goes to DONE.
  - START with either digit > 9: ERR = 1 for exactly one cycle. State and Q are unchanged.
  - STOP in IDLE: no effect.
- RUN:
  - The prescaler counts 0..TICK_DIV-1. A tick occurs on the edge where prescaler == TICK_DIV-1; the prescaler then wraps to 0.
  - The first tick is TICK_DIV edges after the START edge.
  - Tick in mode 0: decrement. U=0 becomes 9 and T decrements.
  - Tick in mode 1: increment. U=9 becomes 0 and T increments.
  - No wrap: a tick whose result is 00 (mode 0) or 99 (mode 1) moves to DONE on the same edge.
  - STOP without a terminal tick goes to PAUSE. A same-edge tick is still applied to Q.
  - Terminal tick together with STOP goes to DONE (terminal wins).
- PAUSE:
  - Q and prescaler are frozen.
  - START resumes RUN with the prescaler continuing from its frozen value.
  - STOP aborts to IDLE and clears Q to 00.
- DONE:
  - Q holds its value.
  - ALARM goes to 1 on the edge entering DONE.
  - The prescaler restarts at 0 on entry. ALARM falls on the edge of the ALARM_TICKS-th tick after entry, i.e. it is high for ALARM_TICKS*TICK_DIV cycles.
  - START or STOP goes to IDLE and clears Q to 00, ALARM and the alarm counter.
- RUN = (state == RUN); DONE = (state == DONE).
- Q never holds a non-BCD value.

Decomposition:
- Package bcd_timer_pkg holds:
  - state encoding constants (IDLE = 0, RUN = 1, PAUSE = 2, DONE = 3)
  - BCD_MAX = 9
  - the mode constants
- One natural sub-module: bcd_pair_counter.
  - Inputs: tick enable, load, up/down.
  - Outputs: 2-digit registered Q and combinational next-value-is-terminal flag.
  - Digit rollover and borrow live here.
- The controller keeps the FSM, prescaler, alarm counter and preset check.

Test Plan:
All scenarios use TICK_DIV = 4 and ALARM_TICKS = 2.
1. Countdown, MODE=0, SET = 1,2, START one cycle:
   - Q = 12 and RUN = 1 after the edge.
   - Q = 11 at +4 edges, 10 at +8, 09 at +12 (borrow).
   - Q = 00, DONE = 1 and ALARM = 1 at +48.
   - ALARM falls 8 edges later; DONE stays 1.
2. Stopwatch, MODE=1, SET = 9,7, START:
   - Q goes 98, then 99 with DONE = 1 at +8.
   - Q stays 99 with no wrap; START then returns IDLE with Q = 00.
3. Invalid preset SET_T = 0xA, START: ERR = 1 for exactly one cycle, state remains IDLE, Q unchanged.
4. Pause and resume:
   - STOP two edges after START gives PAUSE with Q frozen for 10 cycles.
   - START then gives a tick 2 edges later.
   - START and STOP together in PAUSE go to IDLE with Q = 00.
5. Mid-run reset: CLR low asynchronously mid-RUN makes Q = 00 and all flags 0 immediately, without waiting for an edge. After release, no tick occurs without a START.
6. Countdown with SET = 0,0 and START: DONE = 1 and ALARM = 1 directly after the START edge; RUN never asserts.
